red_datapath: RTL and testbench

Execute/write-back stage of the reduced RISC-V single-cycle CPU, sitting directly downstream of the fetch/decode top. Consumes the fetched instruction word, sign-extended immediate and control strobes (RegWrite, ALUctrl, ALUsrc), and holds the 32-entry architectural register file. Performs the ALU operation and writes the result back on the clock edge. Returns the EQ flag that drives branch PC selection, and exposes register a0 (x10) as the program output.

---
 rtl/red_datapath.sv | 94 +++++++++
 tb/tb_red_datapath.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/red_datapath.sv
// rtl/red_datapath.sv - execute/write-back stage: register file, add/sub ALU, EQ flag, a0 output
module red_datapath #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ADDRESS_WIDTH-1:0] instr,
    input  logic [ADDRESS_WIDTH-1:0] ImmOp,
    input  logic                     RegWrite,
    input  logic                     ALUctrl,
    input  logic                     ALUsrc,
    output logic                     EQ,
    output logic [ADDRESS_WIDTH-1:0] a0
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
    localparam int RD_LSB   = 7;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;
    localparam int A0_INDEX = 10;

    // Instruction fields used by this stage
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;

    assign rs1 = instr[RS1_LSB +: REG_ADDR_WIDTH];
    assign rs2 = instr[RS2_LSB +: REG_ADDR_WIDTH];
    assign rd  = instr[RD_LSB  +: REG_ADDR_WIDTH];

    // Opcode/funct bits are decoded upstream; gathered here only so they are visibly consumed
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[ADDRESS_WIDTH-1:RS2_LSB+REG_ADDR_WIDTH],
                                 instr[RS1_LSB-1:RD_LSB+REG_ADDR_WIDTH],
                                 instr[RD_LSB-1:0]};

    // Only x1..x31 have storage; x0 is synthesised as a constant zero on the read ports
    logic [ADDRESS_WIDTH-1:0] regs [1:NUM_REGS-1];

    logic [ADDRESS_WIDTH-1:0] rs1_data;
    logic [ADDRESS_WIDTH-1:0] rs2_data;
    logic [ADDRESS_WIDTH-1:0] alu_op1;
    logic [ADDRESS_WIDTH-1:0] alu_op2;
    logic [ADDRESS_WIDTH-1:0] alu_out;
    logic                     write_en;

    // Asynchronous read ports; index 0 falls through to the zero default
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1 == REG_ADDR_WIDTH'(i)) begin
                rs1_data = regs[i];
            end
            if (rs2 == REG_ADDR_WIDTH'(i)) begin
                rs2_data = regs[i];
            end
        end
    end

    // Operand select and add/subtract; wrap-around is intentional and unflagged
    always_comb begin
        alu_op1 = rs1_data;
        alu_op2 = ALUsrc ? ImmOp : rs2_data;
        alu_out = ALUctrl ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);
    end

    // Branch compare works on the operands, not the ALU result, so it ignores ALUctrl
    assign EQ = (alu_op1 == alu_op2);

    // Writes to x0 are filtered here so no register ever captures them
    assign write_en = en && RegWrite && (rd != '0);

    // Register file write port; reset wins over enable, enable over RegWrite
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (rd == REG_ADDR_WIDTH'(i)) begin
                    regs[i] <= alu_out;
                end
            end
        end
    end

    // Program output straight from x10, no extra register stage
    assign a0 = regs[A0_INDEX];

endmodule

// File: tb/tb_red_datapath.sv
// tb/tb_red_datapath.sv - self-checking bench for red_datapath: directed table plus random model compare
module tb_red_datapath;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] instr;
    logic [31:0] ImmOp;
    logic        RegWrite;
    logic        ALUctrl;
    logic        ALUsrc;
    logic        EQ;
    logic [31:0] a0;

    int checks = 0;
    int errors = 0;

    red_datapath #(
        .ADDRESS_WIDTH (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .instr   (instr),
        .ImmOp   (ImmOp),
        .RegWrite(RegWrite),
        .ALUctrl (ALUctrl),
        .ALUsrc  (ALUsrc),
        .EQ      (EQ),
        .a0      (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic        rw;
        logic        ctrl;
        logic        src;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        exp_eq;
        logic [31:0] exp_a0;
    } vec_t;

    vec_t tbl[$];

    // Architectural reference: 32 registers, x0 forced to zero
    logic [31:0] model [32];

    function automatic vec_t mk(input logic r, input logic e, input logic w, input logic c,
                                input logic s, input int a, input int b, input int d,
                                input logic [31:0] imm, input logic q, input logic [31:0] x);
        vec_t v;
        v.rst = r; v.en = e; v.rw = w; v.ctrl = c; v.src = s;
        v.rs1 = 5'(a); v.rs2 = 5'(b); v.rd = 5'(d);
        v.imm = imm; v.exp_eq = q; v.exp_a0 = x;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one instruction from just after a falling edge, checks EQ in-cycle and a0 after the rising edge
    task automatic run_cycle(input vec_t v, input bit use_model, input string name);
        logic [31:0] op1, op2, res;
        logic        m_eq;
        logic [31:0] filler;
        filler   = $urandom;
        rst      = v.rst;
        en       = v.en;
        RegWrite = v.rw;
        ALUctrl  = v.ctrl;
        ALUsrc   = v.src;
        ImmOp    = v.imm;
        instr    = {filler[31:25], v.rs2, v.rs1, filler[14:12], v.rd, filler[6:0]};
        op1  = model[v.rs1];
        op2  = v.src ? v.imm : model[v.rs2];
        res  = v.ctrl ? op1 - op2 : op1 + op2;
        m_eq = (op1 == op2);
        #2;
        check({name, "_eq"}, {31'b0, EQ}, use_model ? {31'b0, m_eq} : {31'b0, v.exp_eq});
        @(posedge clk);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (v.en && v.rw && v.rd != 5'd0) begin
            model[v.rd] = res;
        end
        #1;
        check({name, "_a0"}, a0, use_model ? model[10] : v.exp_a0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b1; en = 1'b0; instr = '0; ImmOp = '0;
        RegWrite = 1'b0; ALUctrl = 1'b0; ALUsrc = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // rst en rw ctrl src rs1 rs2 rd imm eq a0_after
        tbl.push_back(mk(1,1,0,0,1,  0, 0, 0, 32'h0,        1, 32'h0));        // reset state
        tbl.push_back(mk(0,1,1,0,1,  0, 0,10, 32'h000000FF, 0, 32'h000000FF)); // addi x10,x0,0xff
        tbl.push_back(mk(0,1,1,0,1,  0, 0, 0, 32'h5,        0, 32'h000000FF)); // write to x0 dropped
        tbl.push_back(mk(0,1,0,0,1,  0, 0, 0, 32'h0,        1, 32'h000000FF)); // x0 reads 0
        tbl.push_back(mk(0,1,0,0,1,  0, 0, 0, 32'h5,        0, 32'h000000FF)); // x0 not 5
        tbl.push_back(mk(0,1,1,0,1,  0, 0, 1, 32'hFFFFFFFF, 0, 32'h000000FF)); // x1 = -1
        tbl.push_back(mk(0,1,1,0,1,  1, 0, 1, 32'h1,        0, 32'h000000FF)); // addi x1,x1,1 wraps
        tbl.push_back(mk(0,1,0,0,1,  1, 0, 0, 32'h0,        1, 32'h000000FF)); // x1 == 0
        tbl.push_back(mk(0,1,1,0,1,  0, 0, 2, 32'h3,        0, 32'h000000FF)); // x2 = 3
        tbl.push_back(mk(0,1,1,0,1,  0, 0, 3, 32'h5,        0, 32'h000000FF)); // x3 = 5
        tbl.push_back(mk(0,1,1,1,0,  2, 3, 4, 32'h0,        0, 32'h000000FF)); // sub x4,x2,x3
        tbl.push_back(mk(0,1,0,0,1,  4, 0, 0, 32'hFFFFFFFE, 1, 32'h000000FF)); // x4 == -2
        tbl.push_back(mk(0,1,1,0,0,  4, 0,10, 32'h0,        0, 32'hFFFFFFFE)); // add x10,x4,x0
        tbl.push_back(mk(0,1,1,0,1,  0, 0, 1, 32'h7,        0, 32'hFFFFFFFE)); // x1 = 7
        tbl.push_back(mk(0,1,1,0,1,  0, 0, 2, 32'h7,        0, 32'hFFFFFFFE)); // x2 = 7
        tbl.push_back(mk(0,1,0,0,0,  1, 2, 0, 32'h0,        1, 32'hFFFFFFFE)); // beq x1,x2 taken
        tbl.push_back(mk(0,1,1,0,1,  2, 0, 2, 32'h1,        0, 32'hFFFFFFFE)); // addi x2,x2,1 -> 8
        tbl.push_back(mk(0,1,0,0,0,  1, 2, 0, 32'h0,        0, 32'hFFFFFFFE)); // x1 != x2
        tbl.push_back(mk(0,1,1,1,0,  1, 1, 1, 32'h0,        1, 32'hFFFFFFFE)); // sub x1,x1,x1 reads old
        tbl.push_back(mk(0,1,0,0,1,  1, 0, 0, 32'h0,        1, 32'hFFFFFFFE)); // x1 == 0
        tbl.push_back(mk(0,0,1,0,1,  0, 0,10, 32'h9,        0, 32'hFFFFFFFE)); // stall 1
        tbl.push_back(mk(0,0,1,0,1,  0, 0,10, 32'h9,        0, 32'hFFFFFFFE)); // stall 2
        tbl.push_back(mk(0,0,1,0,1,  0, 0,10, 32'h9,        0, 32'hFFFFFFFE)); // stall 3
        tbl.push_back(mk(0,1,1,0,1,  0, 0,10, 32'h9,        0, 32'h9));        // release stall
        tbl.push_back(mk(1,0,1,0,1,  0, 0,10, 32'h9,        0, 32'h0));        // reset beats en/write

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Every register reads zero after the reset with a pending write
        for (int r = 1; r < 32; r++) begin
            run_cycle(mk(0,1,0,0,1, r, 0, 0, 32'h0, 1, 32'h0), 1'b0, $sformatf("clr_x%0d", r));
        end

        // Randomised program against the reference model
        for (int n = 0; n < 600; n++) begin
            vec_t v;
            int   k;
            v = mk(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 8),
                   ($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
                   (($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 31)),
                   $urandom_range(0, 31),
                   (($urandom_range(0, 2) == 0) ? 10 : $urandom_range(0, 31)),
                   32'h0, 1'b0, 32'h0);
            k = $urandom_range(0, 3);
            if (k == 0)      v.imm = $urandom;
            else if (k == 1) v.imm = 32'($urandom_range(0, 3));
            else if (k == 2) v.imm = model[v.rs1];
            else             v.imm = 32'hFFFFFFFF;
            run_cycle(v, 1'b1, $sformatf("rnd%0d", n));
        end

        // Final sweep of the whole register file through the EQ probe
        for (int r = 0; r < 32; r++) begin
            run_cycle(mk(0,1,0,0,1, r, 0, 0, model[r], 1, 32'h0), 1'b1, $sformatf("fin_x%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
